// File: rtl/l1_l2_arbiter_if.sv
// L1I / L1D / L2-link signal bundle seen by the L1-to-L2 arbiter.
// slave is the arbiter view; master is the view of the surrounding caches and link.
interface l1_l2_arbiter_if;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  logic              l1i_req_i, l1i_rw_i, l1i_write_i, l1i_read_i;
  logic [ADDR_W-1:0] l1i_add_i;
  logic [DATA_W-1:0] l1i_data_i;
  logic              l1d_req_i, l1d_rw_i, l1d_write_i, l1d_read_i;
  logic [ADDR_W-1:0] l1d_add_i;
  logic [DATA_W-1:0] l1d_data_i;
  logic              buf_ready_i, buf_ready_write_i, buf_ready_read_i;
  logic [DATA_W-1:0] buf_data_i;

  logic              buf_req_o, buf_rw_o, buf_write_o, buf_read_o;
  logic [ADDR_W-1:0] buf_add_o;
  logic [DATA_W-1:0] buf_data_o;
  logic              l1i_ready_o, l1i_ready_write_o, l1i_ready_read_o;
  logic [DATA_W-1:0] l1i_data_o;
  logic              l1d_ready_o, l1d_ready_write_o, l1d_ready_read_o;
  logic [DATA_W-1:0] l1d_data_o;
  logic [1:0]        grant_o;
  logic              timeout_o, overrun_o;

  modport slave (
    input  l1i_req_i, l1i_rw_i, l1i_write_i, l1i_read_i, l1i_add_i, l1i_data_i,
    input  l1d_req_i, l1d_rw_i, l1d_write_i, l1d_read_i, l1d_add_i, l1d_data_i,
    input  buf_ready_i, buf_ready_write_i, buf_ready_read_i, buf_data_i,
    output buf_req_o, buf_rw_o, buf_write_o, buf_read_o, buf_add_o, buf_data_o,
    output l1i_ready_o, l1i_ready_write_o, l1i_ready_read_o, l1i_data_o,
    output l1d_ready_o, l1d_ready_write_o, l1d_ready_read_o, l1d_data_o,
    output grant_o, timeout_o, overrun_o
  );

  modport master (
    output l1i_req_i, l1i_rw_i, l1i_write_i, l1i_read_i, l1i_add_i, l1i_data_i,
    output l1d_req_i, l1d_rw_i, l1d_write_i, l1d_read_i, l1d_add_i, l1d_data_i,
    output buf_ready_i, buf_ready_write_i, buf_ready_read_i, buf_data_i,
    input  buf_req_o, buf_rw_o, buf_write_o, buf_read_o, buf_add_o, buf_data_o,
    input  l1i_ready_o, l1i_ready_write_o, l1i_ready_read_o, l1i_data_o,
    input  l1d_ready_o, l1d_ready_write_o, l1d_ready_read_o, l1d_data_o,
    input  grant_o, timeout_o, overrun_o
  );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Grant FSM sharing the L1-to-L2 link between L1I and L1D: whole-transaction grants,
// a dead turnaround cycle between owners, bounded L1D starvation, beat and hold watchdogs.
module l1_l2_arbiter #(
  parameter int unsigned BLOCK_WORDS  = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TIMEOUT      = 1024
) (
  input logic              clock_i,
  input logic              reset_i,
  l1_l2_arbiter_if.slave   bus
);
  localparam int unsigned HOLD_W = $clog2(TIMEOUT);
  localparam int unsigned BEAT_W = $clog2(BLOCK_WORDS + 1);
  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, TURN} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              owner_req, owner_strobe;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      hold_cnt_q <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state: arbitrate in IDLE/TURN, watch the owner while granted.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    owner_req    = 1'b0;
    owner_strobe = 1'b0;

    if (state_q == GNT_I) begin
      owner_req    = bus.l1i_req_i;
      owner_strobe = bus.l1i_write_i | bus.l1i_read_i;
    end else if (state_q == GNT_D) begin
      owner_req    = bus.l1d_req_i;
      owner_strobe = bus.l1d_write_i | bus.l1d_read_i;
    end

    case (state_q)
      IDLE, TURN: begin
        hold_cnt_d = '0;
        beat_cnt_d = '0;
        if (bus.l1i_req_i && bus.l1d_req_i) begin
          if (wait_cnt_q == WAIT_W'(STARVE_LIMIT)) begin
            state_d    = GNT_D;
            wait_cnt_d = '0;
          end else begin
            state_d    = GNT_I;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else if (bus.l1i_req_i) begin
          state_d = GNT_I;
        end else if (bus.l1d_req_i) begin
          state_d    = GNT_D;
          wait_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (owner_strobe) begin
          if (beat_cnt_q == BEAT_W'(BLOCK_WORDS)) overrun_d = 1'b1;
          else beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
        // A forced release only counts as a timeout if the owner still wanted the link.
        if (!owner_req) begin
          state_d = TURN;
        end else if (hold_cnt_q == HOLD_W'(TIMEOUT - 1)) begin
          state_d   = TURN;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux decoded from the registered owner.
  always_comb begin
    bus.buf_req_o         = 1'b0;
    bus.buf_rw_o          = 1'b0;
    bus.buf_write_o       = 1'b0;
    bus.buf_read_o        = 1'b0;
    bus.buf_add_o         = '0;
    bus.buf_data_o        = '0;
    bus.l1i_ready_o       = 1'b0;
    bus.l1i_ready_write_o = 1'b0;
    bus.l1i_ready_read_o  = 1'b0;
    bus.l1i_data_o        = '0;
    bus.l1d_ready_o       = 1'b0;
    bus.l1d_ready_write_o = 1'b0;
    bus.l1d_ready_read_o  = 1'b0;
    bus.l1d_data_o        = '0;
    bus.grant_o           = 2'b00;
    bus.timeout_o         = timeout_q;
    bus.overrun_o         = overrun_q;

    case (state_q)
      GNT_I: begin
        bus.grant_o           = 2'b01;
        bus.buf_req_o         = bus.l1i_req_i;
        bus.buf_rw_o          = bus.l1i_rw_i;
        bus.buf_write_o       = bus.l1i_write_i;
        bus.buf_read_o        = bus.l1i_read_i;
        bus.buf_add_o         = bus.l1i_add_i;
        bus.buf_data_o        = bus.l1i_data_i;
        bus.l1i_ready_o       = bus.buf_ready_i;
        bus.l1i_ready_write_o = bus.buf_ready_write_i;
        bus.l1i_ready_read_o  = bus.buf_ready_read_i;
        bus.l1i_data_o        = bus.buf_data_i;
      end
      GNT_D: begin
        bus.grant_o           = 2'b10;
        bus.buf_req_o         = bus.l1d_req_i;
        bus.buf_rw_o          = bus.l1d_rw_i;
        bus.buf_write_o       = bus.l1d_write_i;
        bus.buf_read_o        = bus.l1d_read_i;
        bus.buf_add_o         = bus.l1d_add_i;
        bus.buf_data_o        = bus.l1d_data_i;
        bus.l1d_ready_o       = bus.buf_ready_i;
        bus.l1d_ready_write_o = bus.buf_ready_write_i;
        bus.l1d_ready_read_o  = bus.buf_ready_read_i;
        bus.l1d_data_o        = bus.buf_data_i;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: vector table for arbitration and forwarding,
// hand sequences for timeout, overrun and asynchronous reset.
module tb_l1_l2_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_l2_arbiter_if bus ();

  l1_l2_arbiter #(.BLOCK_WORDS(4), .STARVE_LIMIT(3), .TIMEOUT(1024)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  localparam logic [23:0] I_ADD  = 24'hA00010;
  localparam logic [31:0] I_DATA = 32'h11110001;
  localparam logic [23:0] D_ADD  = 24'hB00020;
  localparam logic [31:0] D_DATA = 32'h22220002;
  localparam logic [31:0] B_DATA = 32'hCAFEF00D;

  typedef struct {
    logic       i_req;
    logic       d_req;
    logic       i_rd;
    logic       d_wr;
    logic [1:0] exp_grant;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ir, input logic dr, input logic rd, input logic wr,
                              input logic [1:0] g);
    vec_t v;
    v.i_req = ir; v.d_req = dr; v.i_rd = rd; v.d_wr = wr; v.exp_grant = g;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic dr, input logic rd, input logic wr);
    bus.l1i_req_i   = ir;
    bus.l1d_req_i   = dr;
    bus.l1i_read_i  = rd;
    bus.l1d_write_i = wr;
  endtask

  initial begin
    int cnt;
    // L1I-only transaction with four read acks
    vecs[0]  = mk(0,0,0,0,2'b00);
    vecs[1]  = mk(1,0,0,0,2'b00);
    vecs[2]  = mk(1,0,1,0,2'b01);
    vecs[3]  = mk(1,0,1,0,2'b01);
    vecs[4]  = mk(1,0,1,0,2'b01);
    vecs[5]  = mk(1,0,1,0,2'b01);
    vecs[6]  = mk(1,0,0,0,2'b01);
    vecs[7]  = mk(0,0,0,0,2'b01);
    vecs[8]  = mk(0,0,0,0,2'b00);
    vecs[9]  = mk(0,0,0,0,2'b00);
    // Both requesting: three L1I wins, then the starvation override hands L1D the link
    vecs[10] = mk(1,1,0,0,2'b00);
    vecs[11] = mk(1,1,0,0,2'b01);
    vecs[12] = mk(1,1,0,0,2'b01);
    vecs[13] = mk(0,1,0,0,2'b01);
    vecs[14] = mk(1,1,0,0,2'b00);
    vecs[15] = mk(1,1,0,0,2'b01);
    vecs[16] = mk(1,1,0,0,2'b01);
    vecs[17] = mk(0,1,0,0,2'b01);
    vecs[18] = mk(1,1,0,0,2'b00);
    vecs[19] = mk(1,1,0,0,2'b01);
    vecs[20] = mk(1,1,0,0,2'b01);
    vecs[21] = mk(0,1,0,0,2'b01);
    vecs[22] = mk(1,1,0,0,2'b00);
    vecs[23] = mk(1,1,0,1,2'b10);
    vecs[24] = mk(1,1,0,1,2'b10);
    vecs[25] = mk(1,0,0,0,2'b10);
    vecs[26] = mk(1,0,0,0,2'b00);
    vecs[27] = mk(0,1,0,0,2'b01);
    vecs[28] = mk(0,1,0,0,2'b00);
    vecs[29] = mk(0,0,0,0,2'b10);
    vecs[30] = mk(0,0,0,0,2'b00);
    vecs[31] = mk(0,0,0,0,2'b00);

    bus.l1i_rw_i = 1'b0; bus.l1i_write_i = 1'b0; bus.l1i_add_i = I_ADD; bus.l1i_data_i = I_DATA;
    bus.l1d_rw_i = 1'b1; bus.l1d_read_i  = 1'b0; bus.l1d_add_i = D_ADD; bus.l1d_data_i = D_DATA;
    bus.buf_ready_i = 1'b1; bus.buf_ready_write_i = 1'b1; bus.buf_ready_read_i = 1'b1;
    bus.buf_data_i  = B_DATA;
    drive(0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst grant",   32'(bus.grant_o),   32'h0);
    check("rst buf_req", 32'(bus.buf_req_o), 32'h0);
    check("rst buf_add", 32'(bus.buf_add_o), 32'h0);
    check("rst timeout", 32'(bus.timeout_o), 32'h0);
    check("rst overrun", 32'(bus.overrun_o), 32'h0);

    for (int k = 0; k < NV; k++) begin
      logic [1:0]  g;
      tick();
      drive(vecs[k].i_req, vecs[k].d_req, vecs[k].i_rd, vecs[k].d_wr);
      #1;
      g = vecs[k].exp_grant;
      check($sformatf("v%0d grant", k), 32'(bus.grant_o), 32'(g));
      check($sformatf("v%0d buf_req", k), 32'(bus.buf_req_o),
            32'(g == 2'b01 ? vecs[k].i_req : g == 2'b10 ? vecs[k].d_req : 1'b0));
      check($sformatf("v%0d buf_rw", k), 32'(bus.buf_rw_o), 32'(g == 2'b10));
      check($sformatf("v%0d buf_add", k), 32'(bus.buf_add_o),
            32'(g == 2'b01 ? I_ADD : g == 2'b10 ? D_ADD : 24'h0));
      check($sformatf("v%0d buf_data", k), bus.buf_data_o,
            g == 2'b01 ? I_DATA : g == 2'b10 ? D_DATA : 32'h0);
      check($sformatf("v%0d buf_read", k), 32'(bus.buf_read_o),
            32'(g == 2'b01 ? vecs[k].i_rd : 1'b0));
      check($sformatf("v%0d buf_write", k), 32'(bus.buf_write_o),
            32'(g == 2'b10 ? vecs[k].d_wr : 1'b0));
      check($sformatf("v%0d l1i_data", k), bus.l1i_data_o, g == 2'b01 ? B_DATA : 32'h0);
      check($sformatf("v%0d l1i_ready", k), 32'(bus.l1i_ready_o), 32'(g == 2'b01));
      check($sformatf("v%0d l1d_data", k), bus.l1d_data_o, g == 2'b10 ? B_DATA : 32'h0);
      check($sformatf("v%0d l1d_ready_rd", k), 32'(bus.l1d_ready_read_o), 32'(g == 2'b10));
      check($sformatf("v%0d overrun", k), 32'(bus.overrun_o), 32'h0);
    end

    // Timeout: L1D holds its request well beyond TIMEOUT
    tick();
    drive(0, 1, 0, 0);
    #1;
    check("to idle grant", 32'(bus.grant_o), 32'h0);
    tick();
    cnt = 0;
    while (bus.grant_o == 2'b10 && cnt < 1200) begin
      cnt++;
      if (cnt == 1024) check("to flag before", 32'(bus.timeout_o), 32'h0);
      tick();
    end
    check("to granted cycles", 32'(cnt), 32'd1024);
    check("to turn grant",     32'(bus.grant_o), 32'h0);
    check("to flag set",       32'(bus.timeout_o), 32'h1);
    tick();
    check("to regrant",        32'(bus.grant_o), 32'h2);
    repeat (70) tick();
    drive(0, 0, 0, 0);
    #1;
    tick();
    tick();
    check("to back idle",      32'(bus.grant_o), 32'h0);
    check("to flag sticky",    32'(bus.timeout_o), 32'h1);

    // Overrun: five write strobes in one L1I grant, then reset mid-grant
    tick();
    drive(1, 0, 0, 0);
    #1;
    check("ov idle grant", 32'(bus.grant_o), 32'h0);
    for (int b = 0; b < 5; b++) begin
      tick();
      bus.l1i_write_i = 1'b1;
      #1;
      check($sformatf("ov beat%0d grant", b), 32'(bus.grant_o), 32'h1);
      check($sformatf("ov beat%0d wr", b), 32'(bus.buf_write_o), 32'h1);
      check($sformatf("ov beat%0d flag", b), 32'(bus.overrun_o), 32'h0);
    end
    tick();
    bus.l1i_write_i = 1'b0;
    #1;
    check("ov flag set",   32'(bus.overrun_o), 32'h1);
    check("ov still gnt",  32'(bus.grant_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst grant",    32'(bus.grant_o), 32'h0);
    check("arst buf_req",  32'(bus.buf_req_o), 32'h0);
    check("arst ready",    32'(bus.l1i_ready_o), 32'h0);
    check("arst overrun",  32'(bus.overrun_o), 32'h0);
    check("arst timeout",  32'(bus.timeout_o), 32'h0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post rst grant", 32'(bus.grant_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l1_l2_arbiter.md
# l1_l2_arbiter

Registered two-requester arbiter that shares the single L1→L2 link (the txrx_buffer_L2_L1 channel) between the L1 instruction cache and the L1 data cache. It replaces the free-running mem_access selector with an explicit grant state machine: it holds a grant for a whole transaction, enforces a dead turnaround cycle between owners and bounds data-cache starvation. It also watches each transaction with a beat counter and a timeout. It sits between the two L1 caches and the L1 side of the L2 comm buffer inside the 2-level memory controller.

## Interface
- BLOCK_WORDS, 4: data beats per cache block transfer.
- STARVE_LIMIT, 3: consecutive L1D losses before L1D is forced to win a tie.
- TIMEOUT, 1024: maximum cycles a grant may be held.
- clock_i  in  1  controller clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- l1i_req_i, l1i_rw_i, l1i_write_i, l1i_read_i  in  1 each  L1I request, direction, write strobe, read ack.
- l1i_add_i  in  24  L1I word address.
- l1i_data_i  in  32  L1I write data.
- l1d_req_i, l1d_rw_i, l1d_write_i, l1d_read_i, l1d_add_i, l1d_data_i  in  1/1/1/1/24/32  same fields for L1D.
- buf_ready_i, buf_ready_write_i, buf_ready_read_i  in  1 each  L2 link ready, write-ready and read-ready.
- buf_data_i  in  32  read data from the L2 link.
- buf_req_o, buf_rw_o, buf_write_o, buf_read_o  out  1 each  forwarded request fields of the current owner.
- buf_add_o  out  24  forwarded address of the current owner.
- buf_data_o  out  32  forwarded write data of the current owner.
- l1i_ready_o, l1i_ready_write_o, l1i_ready_read_o  out  1 each  link status to L1I, gated by grant.
- l1i_data_o  out  32  read data to L1I, gated by grant.
- l1d_ready_o, l1d_ready_write_o, l1d_ready_read_o, l1d_data_o  out  1/1/1/32  same returns to L1D.
- grant_o  out  2  one-hot owner: bit0 = L1I, bit1 = L1D, 00 = none.
- timeout_o  out  1  sticky: a grant exceeded TIMEOUT.
- overrun_o  out  1  sticky: a transaction exceeded BLOCK_WORDS beats.

## Operation
- FSM states:
  - IDLE: no owner.
  - GNT_I: L1I owns the link.
  - GNT_D: L1D owns the link.
  - TURN: one dead cycle between owners.
- Arbitration is evaluated in IDLE and in TURN:
  - Only one requester asserted → it is granted.
  - Both asserted → L1I wins, unless wait_cnt == STARVE_LIMIT, in which case L1D wins.
  - Neither asserted → go to / stay in IDLE.
- wait_cnt:
  - Increments, saturating at STARVE_LIMIT, on each arbitration where L1D requested and L1I won.
  - Clears on entry to GNT_D.
- Grant release:
  - GNT_x moves to TURN when that owner's req is sampled low.
  - GNT_x also moves to TURN when hold_cnt reaches TIMEOUT-1; this sets timeout_o.
- Forwarding and gating:
  - In GNT_x, all buf_*_o fields equal the owner's inputs, and the owner's ready/data outputs equal the buf_* inputs.
  - The non-owner's ready/data outputs are 0.
  - In IDLE and TURN, every buf_*_o and every L1 return output is 0.
- beat_cnt:
  - Clears on grant entry.
  - Increments on each cycle where the owner's write or read strobe is high.
  - A strobe seen while beat_cnt == BLOCK_WORDS sets overrun_o; the beat is still forwarded.
- timeout_o and overrun_o clear only on reset.

## Timing
- Reset (asynchronous assert):
  - State → IDLE; grant_o = 00.
  - wait_cnt, hold_cnt, beat_cnt = 0; timeout_o = overrun_o = 0.
  - All outputs 0 immediately, because they are decoded from registered state.
- Grant latency: a request sampled at edge k → grant_o and forwarded buf_req_o valid after edge k (one cycle).
- Release: owner req sampled low at edge k → TURN after edge k. Next owner granted after edge k+1. Minimum gap 1 cycle.
- Simultaneous request rise: L1I wins (unless starvation override); L1D is granted after the L1I release plus TURN.
- Owner req dropped and re-raised in the same cycle it is sampled low: it still passes through TURN, then re-arbitrates.
- Reset mid-transaction: grant drops asynchronously; the buf_* request is withdrawn the same cycle.
- Counter widths:
  - hold_cnt: $clog2(TIMEOUT).
  - beat_cnt: $clog2(BLOCK_WORDS+1), saturating.
  - wait_cnt: $clog2(STARVE_LIMIT+1).

## Test plan
- Reset → after release of reset_i: grant_o = 00, all buf_*_o = 0, timeout_o = overrun_o = 0.
- L1I only, req high for 6 cycles with 4 read acks → grant_o = 01 one cycle later; l1d_* returns stay 0; beat_cnt = 4; overrun_o stays 0.
- Both requesting continuously, each dropping req after 3 granted cycles → sequence 01,01,01,00,01,… for 3 L1I grants; the 4th decision grants 10 because wait_cnt = 3.
- Owner drops req → exactly one cycle with grant_o = 00 before the waiting L1D receives grant_o = 10.
- L1D holds req for 1100 cycles with TIMEOUT = 1024 → TURN after 1024 granted cycles; timeout_o = 1 and stays 1.
- 5 write strobes in one L1I grant with BLOCK_WORDS = 4 → overrun_o = 1 on the cycle after the 5th strobe; async reset mid-grant drops grant_o to 00 in the same cycle.
